// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage. Holds the PC, addresses the
//            combinational instruction memory and registers the returned
//            word into the IF/ID pipeline register. Handles sequential
//            advance, redirect, stall, flush and misaligned-target fault.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  pc_src,
    input  logic [DATA_WIDTH-1:0] pc_target,
    output logic [DATA_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr_in,
    output logic [DATA_WIDTH-1:0] if_id_pc,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic                  if_id_valid,
    output logic                  fetch_fault,
    output logic [DATA_WIDTH-1:0] fault_addr,
    output logic [31:0]           fetch_count
);

    localparam logic [DATA_WIDTH-1:0] c_pc_step = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] c_zero    = '0;
    localparam logic [31:0]           c_one     = 32'd1;

    // BOOT spends exactly one edge inserting a bubble so the first real
    // fetch lands on the second edge after reset; FAULT is terminal.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_if_id_pc;
    logic [DATA_WIDTH-1:0] r_if_id_pc_plus4;
    logic [DATA_WIDTH-1:0] r_if_id_instr;
    logic                  r_if_id_valid;
    logic                  r_fault;
    logic [DATA_WIDTH-1:0] r_fault_addr;
    logic [31:0]           r_count;

    // Control decisions for the coming edge
    logic                  w_pc_hold;
    logic                  w_pc_redirect;
    logic                  w_ifid_hold;
    logic                  w_ifid_bubble;
    logic                  w_ifid_load;
    logic                  w_fault_set;
    logic                  w_misaligned;

    // Next-value datapath
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic [DATA_WIDTH-1:0] w_if_id_pc_nxt;
    logic [DATA_WIDTH-1:0] w_if_id_pc_plus4_nxt;
    logic [DATA_WIDTH-1:0] w_if_id_instr_nxt;
    logic                  w_if_id_valid_nxt;
    logic                  w_fault_nxt;
    logic [DATA_WIDTH-1:0] w_fault_addr_nxt;
    logic [31:0]           w_count_nxt;

    // Sequential increment wraps naturally modulo 2^DATA_WIDTH
    assign w_pc_plus4   = r_pc + c_pc_step;
    assign w_misaligned = (pc_target[1:0] != 2'b00);

    // State register and all pipeline/status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_BOOT;
            r_pc             <= RESET_PC;
            r_if_id_pc       <= c_zero;
            r_if_id_pc_plus4 <= c_zero;
            r_if_id_instr    <= NOP_INSTR;
            r_if_id_valid    <= 1'b0;
            r_fault          <= 1'b0;
            r_fault_addr     <= c_zero;
            r_count          <= 32'd0;
        end else begin
            r_state          <= w_state_nxt;
            r_pc             <= w_pc_nxt;
            r_if_id_pc       <= w_if_id_pc_nxt;
            r_if_id_pc_plus4 <= w_if_id_pc_plus4_nxt;
            r_if_id_instr    <= w_if_id_instr_nxt;
            r_if_id_valid    <= w_if_id_valid_nxt;
            r_fault          <= w_fault_nxt;
            r_fault_addr     <= w_fault_addr_nxt;
            r_count          <= w_count_nxt;
        end
    end

    // Next-state and per-edge control decode in priority order:
    // misaligned redirect, redirect, stall, flush, normal fetch
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_hold     = 1'b1;
        w_pc_redirect = 1'b0;
        w_ifid_hold   = 1'b0;
        w_ifid_bubble = 1'b1;
        w_ifid_load   = 1'b0;
        w_fault_set   = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end

            ST_RUN: begin
                if (pc_src && w_misaligned) begin
                    w_fault_set = 1'b1;
                    w_state_nxt = ST_FAULT;
                end else if (pc_src) begin
                    // Redirect wins over stall and flush
                    w_pc_hold     = 1'b0;
                    w_pc_redirect = 1'b1;
                end else if (stall) begin
                    // A flush during a stall still kills the IF/ID word
                    w_ifid_hold   = !flush;
                    w_ifid_bubble = flush;
                end else if (flush) begin
                    w_pc_hold = 1'b0;
                end else begin
                    w_pc_hold     = 1'b0;
                    w_ifid_bubble = 1'b0;
                    w_ifid_load   = 1'b1;
                end
            end

            ST_FAULT: begin
                // Frozen: inputs ignored, bubbles only, until reset
                w_state_nxt = ST_FAULT;
            end

            default: begin
                w_state_nxt = ST_FAULT;
            end
        endcase
    end

    // PC, IF/ID, fault capture and fetch counter next values
    always_comb begin
        w_pc_nxt             = r_pc;
        w_if_id_pc_nxt       = r_if_id_pc;
        w_if_id_pc_plus4_nxt = r_if_id_pc_plus4;
        w_if_id_instr_nxt    = r_if_id_instr;
        w_if_id_valid_nxt    = r_if_id_valid;
        w_fault_nxt          = r_fault;
        w_fault_addr_nxt     = r_fault_addr;
        w_count_nxt          = r_count;

        if (w_pc_redirect) begin
            w_pc_nxt = pc_target;
        end else if (!w_pc_hold) begin
            w_pc_nxt = w_pc_plus4;
        end

        if (w_ifid_load) begin
            w_if_id_pc_nxt       = r_pc;
            w_if_id_pc_plus4_nxt = w_pc_plus4;
            w_if_id_instr_nxt    = instr_in;
            w_if_id_valid_nxt    = 1'b1;
            w_count_nxt          = r_count + c_one;
        end else if (w_ifid_bubble && !w_ifid_hold) begin
            w_if_id_pc_nxt       = c_zero;
            w_if_id_pc_plus4_nxt = c_zero;
            w_if_id_instr_nxt    = NOP_INSTR;
            w_if_id_valid_nxt    = 1'b0;
        end

        if (w_fault_set) begin
            w_fault_nxt      = 1'b1;
            w_fault_addr_nxt = pc_target;
        end
    end

    // Memory address comes straight from the PC register only
    assign instr_addr     = r_pc;
    assign if_id_pc       = r_if_id_pc;
    assign if_id_pc_plus4 = r_if_id_pc_plus4;
    assign if_id_instr    = r_if_id_instr;
    assign if_id_valid    = r_if_id_valid;
    assign fetch_fault    = r_fault;
    assign fault_addr     = r_fault_addr;
    assign fetch_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Scoreboard bench for fetch_stage against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, pc_src = 1'b0;
    logic [31:0] pc_target = '0;
    logic [31:0] instr_addr, instr_in, if_id_pc, if_id_pc_plus4, if_id_instr;
    logic        if_id_valid, fetch_fault;
    logic [31:0] fault_addr, fetch_count;

    // Second instance with a reset PC near the top of the address space
    logic        rst2 = 1'b1;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = '0;
    logic [31:0] addr2, instr2, pc2, p42, ins2, faddr2, cnt2;
    logic        val2, flt2;

    logic [31:0] mem [0:1023];

    assign instr_in = mem[instr_addr[11:2]];
    assign instr2   = mem[addr2[11:2]];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc_src(pc_src),
        .pc_target(pc_target), .instr_addr(instr_addr), .instr_in(instr_in),
        .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .fetch_fault(fetch_fault), .fault_addr(fault_addr),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst2), .stall(zero_bit), .flush(zero_bit),
        .pc_src(zero_bit), .pc_target(zero_word), .instr_addr(addr2),
        .instr_in(instr2), .if_id_pc(pc2), .if_id_pc_plus4(p42),
        .if_id_instr(ins2), .if_id_valid(val2), .fetch_fault(flt2),
        .fault_addr(faddr2), .fetch_count(cnt2)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc, ipc, ip4, ins, fa, cnt;
        logic        val, flt;
    } exp_t;

    exp_t q[$];

    int          m_phase;          // 0 first edge after reset, 1 running, 2 faulted
    logic [31:0] m_pc, m_ipc, m_ip4, m_ins, m_fa, m_cnt;
    logic        m_val, m_flt;

    task automatic model_reset();
        m_phase = 0; m_pc = 32'h0; m_ipc = 0; m_ip4 = 0; m_ins = c_nop;
        m_val = 0; m_flt = 0; m_fa = 0; m_cnt = 0;
    endtask

    task automatic model_bubble();
        m_ipc = 0; m_ip4 = 0; m_ins = c_nop; m_val = 0;
    endtask

    task automatic model_edge(input logic s, input logic f, input logic src, input logic [31:0] tgt);
        if (m_phase == 0) begin
            model_bubble();
            m_phase = 1;
        end else if (m_phase == 2) begin
            model_bubble();
        end else if (src && (tgt % 4 != 0)) begin
            model_bubble(); m_flt = 1; m_fa = tgt; m_phase = 2;
        end else if (src) begin
            model_bubble(); m_pc = tgt;
        end else if (s) begin
            if (f) model_bubble();
        end else if (f) begin
            model_bubble(); m_pc = m_pc + 4;
        end else begin
            m_ipc = m_pc; m_ip4 = m_pc + 4; m_ins = mem[m_pc[11:2]];
            m_val = 1; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
        end
    endtask

    // Drive one cycle's inputs before the edge and queue the expected result
    task automatic run_cycle(input logic s, input logic f, input logic src, input logic [31:0] tgt);
        exp_t e;
        stall = s; flush = f; pc_src = src; pc_target = tgt;
        model_edge(s, f, src, tgt);
        e.pc = m_pc; e.ipc = m_ipc; e.ip4 = m_ip4; e.ins = m_ins;
        e.val = m_val; e.flt = m_flt; e.fa = m_fa; e.cnt = m_cnt;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst instr_addr", instr_addr, 32'h0);
        check("rst if_id_pc", if_id_pc, 32'h0);
        check("rst if_id_pc_plus4", if_id_pc_plus4, 32'h0);
        check("rst if_id_instr", if_id_instr, c_nop);
        check("rst if_id_valid", {31'd0, if_id_valid}, 32'h0);
        check("rst fetch_fault", {31'd0, fetch_fault}, 32'h0);
        check("rst fault_addr", fault_addr, 32'h0);
        check("rst fetch_count", fetch_count, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        model_reset();
        stall = 0; flush = 0; pc_src = 0; pc_target = 0;
        #2;
        check_reset_state();
        rst = 1'b0;
    endtask

    // Monitor: compares the DUT against each queued expectation after its edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("instr_addr", instr_addr, e.pc);
                check("if_id_pc", if_id_pc, e.ipc);
                check("if_id_pc_plus4", if_id_pc_plus4, e.ip4);
                check("if_id_instr", if_id_instr, e.ins);
                check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.val});
                check("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.flt});
                check("fault_addr", fault_addr, e.fa);
                check("fetch_count", fetch_count, e.cnt);
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        logic [31:0] tgt;
        logic [31:0] held;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        @(negedge clk);
        do_reset();

        // Sequential fetch of the first four words
        for (int i = 0; i < 5; i++) run_cycle(0, 0, 0, 0);
        check("t1 fetch_count", fetch_count, 32'd4);
        check("t1 last instr", if_id_instr, mem[3]);
        check("t1 last pc", if_id_pc, 32'hC);

        // Stall after B has been loaded
        do_reset();
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle(1, 0, 0, 0);
        check("t2 addr held", instr_addr, 32'h8);
        check("t2 instr held", if_id_instr, mem[1]);
        check("t2 valid held", {31'd0, if_id_valid}, 32'd1);
        run_cycle(0, 0, 0, 0);
        check("t2 release instr", if_id_instr, mem[2]);
        check("t2 release pc", if_id_pc, 32'h8);

        // Redirect overriding stall and flush
        run_cycle(1, 1, 1, 32'h40);
        check("t3 pc", instr_addr, 32'h40);
        check("t3 valid", {31'd0, if_id_valid}, 32'd0);
        run_cycle(0, 0, 0, 0);
        check("t3 instr", if_id_instr, mem[16]);
        check("t3 if_id_pc", if_id_pc, 32'h40);

        // Misaligned redirect faults and freezes
        held = instr_addr;
        run_cycle(0, 0, 1, 32'h42);
        check("t4 fault", {31'd0, fetch_fault}, 32'd1);
        check("t4 fault_addr", fault_addr, 32'h42);
        check("t4 pc held", instr_addr, held);
        run_cycle(0, 0, 1, 32'h80);
        run_cycle(0, 1, 0, 0);
        check("t4 pc frozen", instr_addr, held);
        check("t4 valid", {31'd0, if_id_valid}, 32'd0);
        check("t4 fault_addr held", fault_addr, 32'h42);

        // Asynchronous reset mid-cycle, away from any edge
        do_reset();
        for (int i = 0; i < 6; i++) run_cycle(0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_state();
        @(negedge clk);
        do_reset();
        run_cycle(0, 0, 0, 0);
        check("t6 boot idle", {31'd0, if_id_valid}, 32'd0);
        run_cycle(0, 0, 0, 0);
        check("t6 refetch pc", if_id_pc, 32'h0);

        // Randomized episodes
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                int r;
                r = $urandom_range(0, 15);
                if (r == 0)      tgt = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
                else if (r == 1) tgt = 32'hFFFF_FFF0 | (($urandom % 4) << 2);
                else             tgt = $urandom & 32'h0000_0FFC;
                run_cycle(($urandom % 4) == 0, ($urandom % 6) == 0,
                          ($urandom % 10) == 0, tgt);
            end
        end
        @(posedge clk);
        #2;

        // Wrap-around from the top of the address space
        @(negedge clk);
        check("t5 reset pc", addr2, 32'hFFFF_FFF8);
        rst2 = 1'b0;
        @(posedge clk); #1;
        check("t5 boot valid", {31'd0, val2}, 32'd0);
        @(posedge clk); #1;
        check("t5 f1 pc", pc2, 32'hFFFF_FFF8);
        check("t5 f1 pc4", p42, 32'hFFFF_FFFC);
        check("t5 f1 instr", ins2, mem[1022]);
        @(posedge clk); #1;
        check("t5 f2 pc", pc2, 32'hFFFF_FFFC);
        check("t5 f2 pc4", p42, 32'h0);
        check("t5 f2 instr", ins2, mem[1023]);
        check("t5 wrap addr", addr2, 32'h0);
        check("t5 no fault", {31'd0, flt2}, 32'd0);
        check("t5 count", cnt2, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
